// File: rtl/rnbip_pkg.sv
// Shared RNBIP-2 definitions: NOP word, control-transfer opcode groups,
// PC-mux select encoding, fetch FSM state and its debug view.
package rnbip_pkg;

  localparam logic [15:0] NOP = 16'h0000;

  // Control-transfer opcode groups, matched on instruction bits [15:8].
  // Group 0 is 0000_0_xxx with the low three bits in 011..111.
  localparam logic [4:0] OPC_CT_G0     = 5'b00000;
  localparam logic [2:0] OPC_CT_G0_MIN = 3'b011;
  localparam logic [4:0] OPC_CT_G1     = 5'b00001;
  localparam logic [4:0] OPC_CT_G2     = 5'b00101;
  localparam logic [3:0] OPC_CT_G3     = 4'b0011;
  localparam logic [4:0] OPC_CT_G4     = 5'b01001;

  // PC-mux select {S11,S10}
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_OD  = 2'b01;
  localparam logic [1:0] PCSEL_RET = 2'b10;
  localparam logic [1:0] PCSEL_ABS = 2'b11;

  typedef enum logic [1:0] {
    FS_RUN     = 2'd0,
    FS_SHADOW  = 2'd1,
    FS_RESOLVE = 2'd2
  } fetch_state_t;

  // Debug view of the fetch FSM: state plus the "control transfer on
  // segment" flag that starts the bubble sequence.
  typedef struct packed {
    fetch_state_t state;
    logic         ctrl_pend;
  } fetch_dbg_t;

endpackage

// File: rtl/fetch_predecode.sv
// Opcode predecode: flags control-transfer instructions.
module fetch_predecode
  import rnbip_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_ctrl
);

  // Match the opcode against every control-transfer group
  always_comb begin
    is_ctrl = 1'b0;
    if (opcode[7:3] == OPC_CT_G0 && opcode[2:0] >= OPC_CT_G0_MIN) is_ctrl = 1'b1;
    if (opcode[7:3] == OPC_CT_G1) is_ctrl = 1'b1;
    if (opcode[7:3] == OPC_CT_G2) is_ctrl = 1'b1;
    if (opcode[7:4] == OPC_CT_G3) is_ctrl = 1'b1;
    if (opcode[7:3] == OPC_CT_G4) is_ctrl = 1'b1;
  end

endmodule

// File: rtl/fetch_unit.sv
// RNBIP-2 instruction fetch: owns the PC, reads program memory, issues
// segment/PC_in and inserts two bubbles behind every control transfer.
//
// Program-memory handshake: imem_req acts as valid for imem_addr; a read
// completes in any cycle where imem_req=1 and imem_ready=1, and imem_rdata
// is consumed in that same cycle. imem_ready is ignored while imem_req=0.
//
// Bubble timing: a control transfer captured at edge e0 sits on segment in
// c0. During c0 fetch is held off (ctrl_pend) and a NOP is issued, during
// c1 (SHADOW) a second NOP, and during c2 (RESOLVE) the control stage's
// L_PC/select pick the address whose word lands on segment in c3.
module fetch_unit
  import rnbip_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        L_PC,
  input  logic        S11,
  input  logic        S10,
  input  logic [7:0]  OR2,
  input  logic [7:0]  r0_data,
  input  logic [7:0]  dm_rdata,
  output logic [15:0] segment,
  output logic [7:0]  PC_in,
  output logic        seg_valid,
  output fetch_dbg_t  dbg
);

  fetch_state_t state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   pc_in_q, pc_in_d;
  logic [15:0]  seg_q, seg_d;
  logic         valid_q, valid_d;
  logic         pend_q, pend_d;
  logic [7:0]   target;
  logic [7:0]   next_pc;
  logic [7:0]   addr_inc;
  logic         is_ctrl;

  fetch_predecode u_predecode (
    .opcode  (imem_rdata[15:8]),
    .is_ctrl (is_ctrl)
  );

  // PC-mux: target chosen by the control stage's select lines
  always_comb begin
    target = pc_q;
    case ({S11, S10})
      PCSEL_OD:  target = OR2;
      PCSEL_ABS: target = r0_data;
      PCSEL_RET: target = dm_rdata;
      default:   target = pc_q;
    endcase
  end

  // L_PC only steers the PC in RESOLVE
  assign next_pc  = (state_q == FS_RESOLVE && L_PC) ? target : pc_q;
  assign addr_inc = imem_addr + 8'd1;

  // Next-state, fetch request and capture logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_in_d   = pc_in_q;
    seg_d     = NOP;
    valid_d   = 1'b0;
    pend_d    = 1'b0;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      FS_RUN: begin
        if (pend_q) begin
          // Control transfer on segment: no fetch, first NOP
          state_d = FS_SHADOW;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            seg_d   = imem_rdata;
            valid_d = 1'b1;
            pc_d    = addr_inc;
            pc_in_d = addr_inc;
            pend_d  = is_ctrl;
          end
        end
      end
      FS_SHADOW: begin
        state_d = FS_RESOLVE;
      end
      FS_RESOLVE: begin
        imem_req  = 1'b1;
        imem_addr = next_pc;
        state_d   = FS_RUN;
        if (imem_ready) begin
          seg_d   = imem_rdata;
          valid_d = 1'b1;
          pc_d    = addr_inc;
          pc_in_d = addr_inc;
          pend_d  = is_ctrl;
        end else begin
          pc_d = next_pc;
        end
      end
      default: state_d = FS_RUN;
    endcase
  end

  // State and output registers; reset discards any pending jump
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
      pc_in_q <= RESET_PC;
      seg_q   <= NOP;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_in_q <= pc_in_d;
      seg_q   <= seg_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign segment       = seg_q;
  assign PC_in         = pc_in_q;
  assign seg_valid     = valid_q;
  assign dbg.state     = state_q;
  assign dbg.ctrl_pend = pend_q;

endmodule
